// File: rtl/axi4_arb_pkg.sv
// Shared types and width helpers for the AXI4 read-address arbiter.
package axi4_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Fixed-width AR fields; id and user are parameterised and muxed alongside.
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [2:0]  prot;
        logic [3:0]  cache;
    } ar_chan_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/axi4_ar_arbiter_if.sv
// Requester AR ports, muxed AR output and R-channel snoop of the shared read-address channel.
interface axi4_ar_arbiter_if
    import axi4_arb_pkg::*;
#(
    parameter int N_SLV          = 2,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4
);
    localparam int IDX_W    = idx_w(N_SLV);
    localparam int OUT_ID_W = AXI_ID_WIDTH + IDX_W;

    logic [N_SLV*AXI_ID_WIDTH-1:0]   s_axi4_arid;
    logic [N_SLV*32-1:0]             s_axi4_araddr;
    logic [N_SLV*8-1:0]              s_axi4_arlen;
    logic [N_SLV*3-1:0]              s_axi4_arsize;
    logic [N_SLV*2-1:0]              s_axi4_arburst;
    logic [N_SLV-1:0]                s_axi4_arlock;
    logic [N_SLV*3-1:0]              s_axi4_arprot;
    logic [N_SLV*4-1:0]              s_axi4_arcache;
    logic [N_SLV*AXI_USER_WIDTH-1:0] s_axi4_aruser;
    logic [N_SLV-1:0]                s_axi4_arvalid;
    logic [N_SLV-1:0]                s_axi4_arready;

    logic [OUT_ID_W-1:0]             m_axi4_arid;
    logic [31:0]                     m_axi4_araddr;
    logic [7:0]                      m_axi4_arlen;
    logic [2:0]                      m_axi4_arsize;
    logic [1:0]                      m_axi4_arburst;
    logic                            m_axi4_arlock;
    logic [2:0]                      m_axi4_arprot;
    logic [3:0]                      m_axi4_arcache;
    logic [AXI_USER_WIDTH-1:0]       m_axi4_aruser;
    logic                            m_axi4_arvalid;
    logic                            m_axi4_arready;

    logic [OUT_ID_W-1:0]             m_axi4_rid;
    logic                            m_axi4_rlast;
    logic                            m_axi4_rvalid;
    logic                            m_axi4_rready;

    modport slave (
        input  s_axi4_arid, s_axi4_araddr, s_axi4_arlen, s_axi4_arsize, s_axi4_arburst,
               s_axi4_arlock, s_axi4_arprot, s_axi4_arcache, s_axi4_aruser, s_axi4_arvalid,
               m_axi4_arready, m_axi4_rid, m_axi4_rlast, m_axi4_rvalid, m_axi4_rready,
        output s_axi4_arready, m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize,
               m_axi4_arburst, m_axi4_arlock, m_axi4_arprot, m_axi4_arcache, m_axi4_aruser,
               m_axi4_arvalid
    );

    modport master (
        output s_axi4_arid, s_axi4_araddr, s_axi4_arlen, s_axi4_arsize, s_axi4_arburst,
               s_axi4_arlock, s_axi4_arprot, s_axi4_arcache, s_axi4_aruser, s_axi4_arvalid,
               m_axi4_arready, m_axi4_rid, m_axi4_rlast, m_axi4_rvalid, m_axi4_rready,
        input  s_axi4_arready, m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize,
               m_axi4_arburst, m_axi4_arlock, m_axi4_arprot, m_axi4_arcache, m_axi4_aruser,
               m_axi4_arvalid
    );

endinterface

// File: rtl/axi4_rr_sel.sv
// Round-robin pick: first set request at or after ptr, wrapping; purely combinational.
module axi4_rr_sel
    import axi4_arb_pkg::*;
#(
    parameter int  N_SLV = 2,
    localparam int IDX_W = idx_w(N_SLV)
) (
    input  logic [N_SLV-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             any
);
    logic [2*N_SLV-1:0] dbl;
    int                 first;

    // Upper copy supplies the wrapped-around candidates below ptr.
    always_comb begin
        dbl   = {req, req} & ({2*N_SLV{1'b1}} << ptr);
        first = 0;
        for (int j = 2*N_SLV-1; j >= 0; j--) begin
            if (dbl[j]) first = j;
        end
        any = |req;
        sel = (first >= N_SLV) ? IDX_W'(first - N_SLV) : IDX_W'(first);
    end

endmodule

// File: rtl/axi4_ar_arbiter.sv
// Round-robin AR arbiter with 0-cycle grant, grant held until handshake; requester blocked at MAX_OUTST in flight.
// Backpressure: m_axi4_arready routed only to the granted requester; arvalid never depends on arready.
module axi4_ar_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int  N_SLV          = 2,
    parameter int  AXI_ID_WIDTH   = 4,
    parameter int  AXI_USER_WIDTH = 4,
    parameter int  MAX_OUTST      = 8,
    localparam int IDX_W          = idx_w(N_SLV),
    localparam int CNT_W          = cnt_w(MAX_OUTST)
) (
    input  logic                   axi4_aclk,
    input  logic                   axi4_arstn,
    axi4_ar_arbiter_if.slave       bus,
    output logic [N_SLV*CNT_W-1:0] outst_cnt_o,
    output logic                   err_o
);
    localparam int OUT_ID_W = AXI_ID_WIDTH + IDX_W;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, rr_sel, sel, rid_idx;
    logic                      rr_any, m_vld, hs, r_done, err_set, err_q;
    logic [N_SLV-1:0]          elig, inc, dec, cnt_zero;
    logic [CNT_W-1:0]          cnt_q [N_SLV];
    ar_chan_t                  ch [N_SLV];
    logic [AXI_ID_WIDTH-1:0]   id_s [N_SLV];
    logic [AXI_USER_WIDTH-1:0] user_s [N_SLV];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] s);
        return (s == IDX_W'(N_SLV - 1)) ? '0 : s + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_SLV; i++) begin
            ch[i].addr  = bus.s_axi4_araddr[i*32 +: 32];
            ch[i].len   = bus.s_axi4_arlen[i*8 +: 8];
            ch[i].size  = bus.s_axi4_arsize[i*3 +: 3];
            ch[i].burst = bus.s_axi4_arburst[i*2 +: 2];
            ch[i].lock  = bus.s_axi4_arlock[i];
            ch[i].prot  = bus.s_axi4_arprot[i*3 +: 3];
            ch[i].cache = bus.s_axi4_arcache[i*4 +: 4];
            id_s[i]     = bus.s_axi4_arid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH];
            user_s[i]   = bus.s_axi4_aruser[i*AXI_USER_WIDTH +: AXI_USER_WIDTH];
            elig[i]     = bus.s_axi4_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    axi4_rr_sel #(.N_SLV(N_SLV)) u_rr_sel (
        .req (elig),
        .ptr (rr_ptr_q),
        .sel (rr_sel),
        .any (rr_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        sel      = rr_sel;
        m_vld    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    m_vld = 1'b1;
                    if (bus.m_axi4_arready) begin
                        rr_ptr_d = next_idx(rr_sel);
                    end else begin
                        gnt_d   = rr_sel;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                sel   = gnt_q;
                m_vld = 1'b1;
                if (bus.m_axi4_arready) begin
                    rr_ptr_d = next_idx(gnt_q);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!axi4_arstn) m_vld = 1'b0;
        hs = m_vld && bus.m_axi4_arready;
    end

    always_comb begin
        bus.m_axi4_arvalid      = m_vld;
        bus.s_axi4_arready      = '0;
        bus.s_axi4_arready[sel] = hs;
        bus.m_axi4_arid         = {sel, id_s[sel]};
        bus.m_axi4_araddr       = ch[sel].addr;
        bus.m_axi4_arlen        = ch[sel].len;
        bus.m_axi4_arsize       = ch[sel].size;
        bus.m_axi4_arburst      = ch[sel].burst;
        bus.m_axi4_arlock       = ch[sel].lock;
        bus.m_axi4_arprot       = ch[sel].prot;
        bus.m_axi4_arcache      = ch[sel].cache;
        bus.m_axi4_aruser       = user_s[sel];
    end

    // A completion whose index is out of range matches no counter and only raises err.
    always_comb begin
        rid_idx = bus.m_axi4_rid[OUT_ID_W-1 -: IDX_W];
        r_done  = bus.m_axi4_rvalid && bus.m_axi4_rready && bus.m_axi4_rlast;
        for (int i = 0; i < N_SLV; i++) begin
            inc[i]      = hs && (sel == IDX_W'(i));
            dec[i]      = r_done && (rid_idx == IDX_W'(i));
            cnt_zero[i] = (cnt_q[i] == '0);
            outst_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
        err_set = r_done && ((int'(rid_idx) >= N_SLV) || (|(dec & cnt_zero)));
        err_o   = err_q;
    end

    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            for (int i = 0; i < N_SLV; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLV; i++) begin
                if (inc[i] && !dec[i] && (cnt_q[i] != CNT_W'(MAX_OUTST))) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (dec[i] && !inc[i] && !cnt_zero[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    // A locked requester must keep arvalid up until its handshake.
    a_hold_valid: assert property (@(posedge axi4_aclk) disable iff (!axi4_arstn)
        (state_q == LOCKED) |-> bus.s_axi4_arvalid[gnt_q]);

endmodule
